tx_packet_framer: RTL and testbench

Serial packet transmitter: the transmit-side counterpart of the RX shift-buffer/packet-detect path. It collects a fixed-length payload byte-by-byte from the SPI/config side and frames it as preamble + sync word + payload, MSB first. It then shifts the frame onto a single-bit modulator line at a programmable bit period. It sits between the SPI slave output register and the TX_OUT OR-gate in TOP.

---
 rtl/tx_packet_framer.sv | 219 +++++++++++++++++++++
 tb/tb_tx_packet_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_framer.sv
// tx_packet_framer
//
// Collects PKT_BYTES payload bytes, then serialises a frame
// (PREAMBLE, SYNC_WORD, payload bytes in arrival order) MSB first.
// Each bit is held for a latched number of clk cycles.
//
// Optional feature macro: TX_PARITY_EN. When defined, one even-parity
// bit (XOR of all payload bits) is appended after the payload.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active low
//   byte_in     payload byte from the SPI side
//   byte_valid  byte_in is valid
//   byte_ready  a byte is accepted this cycle if byte_valid is high
//   bit_period  clk cycles per bit, latched at frame start (0 acts as 1)
//   abort       synchronous abort of a load or frame in progress
//   tx_out      registered serial output
//   busy        frame in progress (preamble through last bit)
//   done        one-cycle pulse after the last bit period completes
module tx_packet_framer #(
  parameter int          PKT_BYTES = 3,
  parameter logic [7:0]  PREAMBLE  = 8'hAA,
  parameter logic [7:0]  SYNC_WORD = 8'hB4,
  parameter int          CNT_W     = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic [CNT_W-1:0] bit_period,
  input  logic             abort,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  // Byte counters are sized for the largest legal PKT_BYTES (15).
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             tx_q, tx_d;
  logic [7:0]       payload_q [PKT_BYTES];
  logic             wr_en;
  logic [7:0]       cur_byte;

  assign byte_ready = (state_q == S_IDLE) && (load_cnt_q < IDX_W'(PKT_BYTES));
  assign done       = (state_q == S_DONE);
  assign tx_out     = tx_q;

  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_PREAMBLE, S_SYNC, S_PAYLOAD: busy = 1'b1;
`ifdef TX_PARITY_EN
      S_PARITY: busy = 1'b1;
`endif
      default: busy = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    wr_en      = 1'b0;

    if (abort) begin
      // Abort wins over a byte offered in the same cycle.
      state_d    = S_IDLE;
      load_cnt_d = '0;
      cnt_d      = '0;
      bit_idx_d  = '0;
      byte_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (byte_valid && byte_ready) begin
            wr_en = 1'b1;
            if (load_cnt_q == IDX_W'(PKT_BYTES - 1)) begin
              state_d    = S_PREAMBLE;
              load_cnt_d = '0;
              period_d   = (bit_period == '0) ? CNT_W'(1) : bit_period;
              cnt_d      = '0;
              bit_idx_d  = '0;
              byte_idx_d = '0;
            end else begin
              load_cnt_d = load_cnt_q + IDX_W'(1);
            end
          end
        end

        S_DONE: begin
          state_d    = S_IDLE;
          load_cnt_d = '0;
        end

        default: begin
          // Transmit states: hold each bit for period_q cycles.
          if (cnt_q != period_q - CNT_W'(1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d     = '0;
            bit_idx_d = bit_idx_q + 3'd1;   // wraps 7 -> 0 at byte end
            if (bit_idx_q == 3'd7) begin
              case (state_q)
                S_PREAMBLE: state_d = S_SYNC;
                S_SYNC: begin
                  state_d    = S_PAYLOAD;
                  byte_idx_d = '0;
                end
                S_PAYLOAD: begin
                  if (byte_idx_q == IDX_W'(PKT_BYTES - 1)) begin
`ifdef TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_DONE;
`endif
                  end else begin
                    byte_idx_d = byte_idx_q + IDX_W'(1);
                  end
                end
                default: ;
              endcase
            end
`ifdef TX_PARITY_EN
            // Parity is a single bit, so it ends after one period.
            if (state_q == S_PARITY) state_d = S_DONE;
`endif
          end
        end
      endcase
    end
  end

  // Payload byte currently addressed by the next bit position.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < PKT_BYTES; i++) begin
      if (byte_idx_d == IDX_W'(i)) cur_byte = payload_q[i];
    end
  end

`ifdef TX_PARITY_EN
  logic parity;
  always_comb begin
    parity = 1'b0;
    for (int i = 0; i < PKT_BYTES; i++) parity = parity ^ (^payload_q[i]);
  end
`endif

  // The output flop loads the bit belonging to the next position, so the
  // first preamble bit appears the cycle after the last byte is accepted.
  always_comb begin
    tx_d = 1'b0;
    case (state_d)
      S_PREAMBLE: tx_d = PREAMBLE[3'd7 - bit_idx_d];
      S_SYNC:     tx_d = SYNC_WORD[3'd7 - bit_idx_d];
      S_PAYLOAD:  tx_d = cur_byte[3'd7 - bit_idx_d];
`ifdef TX_PARITY_EN
      S_PARITY:   tx_d = parity;
`endif
      default:    tx_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      period_q   <= CNT_W'(1);
      tx_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      tx_q       <= tx_d;
    end
  end

  // Payload store, written in arrival order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PKT_BYTES; i++) payload_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < PKT_BYTES; i++) begin
        if (load_cnt_q == IDX_W'(i)) payload_q[i] <= byte_in;
      end
    end
  end

endmodule

// File: tb/tb_tx_packet_framer.sv
module tb_tx_packet_framer;

  localparam int         PKT_BYTES = 3;
  localparam int         CNT_W     = 14;
  localparam logic [7:0] PRE_V     = 8'hAA;
  localparam logic [7:0] SYNC_V    = 8'hB4;
`ifdef TX_PARITY_EN
  localparam int         PAR_BITS  = 1;
`else
  localparam int         PAR_BITS  = 0;
`endif
  localparam int         N_BITS    = 16 + 8 * PKT_BYTES + PAR_BITS;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [CNT_W-1:0] bit_period;
  logic             abort;
  logic             tx_out;
  logic             busy;
  logic             done;

  tx_packet_framer #(
    .PKT_BYTES(PKT_BYTES), .PREAMBLE(PRE_V), .SYNC_WORD(SYNC_V), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .bit_period(bit_period), .abort(abort),
    .tx_out(tx_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Expected per-cycle outputs {tx_out, busy, done, byte_ready}; empty = idle.
  logic [3:0] exp_q[$];
  logic       obs[$];          // tx_out on every busy cycle
  int         busy_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] data [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: a frame is the list of its bits, each repeated for the latched
  // period, followed by one done cycle.
  initial begin
    int         load;
    logic [7:0] pay [PKT_BYTES];
    logic [3:0] cur;
    logic [7:0] pre, syn;
    logic       fbits[$];
    int         per;
    int         ones;
    load = 0;
    forever begin
      @(posedge clk);
      cur = (exp_q.size() == 0) ? 4'b0001 : exp_q[0];
      if (rst !== 1'b1 || abort === 1'b1) begin
        exp_q.delete();
        load = 0;
      end else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (cur[0] && byte_valid === 1'b1) begin
          pay[load] = byte_in;
          load++;
          if (load == PKT_BYTES) begin
            load = 0;
            pre  = PRE_V;
            syn  = SYNC_V;
            per  = (bit_period == 0) ? 1 : int'(bit_period);
            fbits.delete();
            ones = 0;
            for (int i = 7; i >= 0; i--) fbits.push_back(pre[i]);
            for (int i = 7; i >= 0; i--) fbits.push_back(syn[i]);
            for (int b = 0; b < PKT_BYTES; b++) begin
              for (int i = 7; i >= 0; i--) fbits.push_back(pay[b][i]);
              ones += $countones(pay[b]);
            end
            if (PAR_BITS == 1) fbits.push_back(ones[0]);
            foreach (fbits[k])
              for (int r = 0; r < per; r++) exp_q.push_back({fbits[k], 3'b100});
            exp_q.push_back(4'b0010);
          end
        end
      end
    end
  end

  // Compare process: every cycle once checking is enabled.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = (exp_q.size() == 0) ? 4'b0001 : exp_q[0];
        chk("cycle{tx,busy,done,ready}", {60'd0, tx_out, busy, done, byte_ready}, {60'd0, e});
        if (busy === 1'b1) begin
          obs.push_back(tx_out);
          busy_cnt++;
        end
        if (done === 1'b1) done_cnt++;
      end
    end
  end

  // Offer bytes data[0..n-1] with byte_valid held; advance only on acceptance.
  task automatic send_bytes(input int n);
    int   k = 0;
    int   guard = 0;
    logic rdy;
    while (k < n && guard < 2000) begin
      byte_in    = data[k];
      byte_valid = 1'b1;
      rdy        = byte_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) k++;
      guard++;
    end
    byte_valid = 1'b0;
    chk("send_accept_count", k, n);
  endtask

  task automatic wait_done(input int maxc);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen_before_timeout", (done_cnt != d0) ? 1 : 0, 1);
  endtask

  initial begin
    int         b0, ob, d0;
    logic [39:0] exp_stream;
    logic [39:0] got;

    rst = 1'b0; byte_in = '0; byte_valid = 1'b0; bit_period = 14'd4; abort = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_tx_out", tx_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_byte_ready", byte_ready, 1);
    @(posedge clk); #1;

    // Basic frame, period 4.
    data[0] = 8'h12; data[1] = 8'h34; data[2] = 8'h56;
    bit_period = 14'd4;
    b0 = busy_cnt; ob = obs.size(); d0 = done_cnt;
    send_bytes(3);
    chk("first_bit_after_accept", tx_out, 1);
    wait_done(400);
    chk("p4_busy_cycles", busy_cnt - b0, 160 + 4 * PAR_BITS);
    chk("p4_done_pulses", done_cnt - d0, 1);
    chk("p4_ready_after_done", byte_ready, 1);
    exp_stream = 40'hAAB4123456;
    got = '0;
    for (int i = 0; i < 40; i++) got[39 - i] = obs[ob + i * 4];
    chk("p4_bit_stream", got, exp_stream);
    if (PAR_BITS == 1) chk("p4_parity_bit", obs[ob + 160], 1);

    // Period 0 acts as 1; mid-frame period change ignored.
    bit_period = 14'd0;
    b0 = busy_cnt;
    send_bytes(3);
    repeat (5) @(posedge clk);
    #1 bit_period = 14'd10;
    wait_done(400);
    chk("p0_busy_cycles", busy_cnt - b0, 40 + PAR_BITS);

    // Abort at cycle 50 of a frame.
    bit_period = 14'd4;
    d0 = done_cnt;
    send_bytes(3);
    repeat (50) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_tx_out", tx_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", byte_ready, 1);
    repeat (200) @(posedge clk);
    #1 chk("abort_no_done", done_cnt - d0, 0);

    // Fresh load after abort.
    data[0] = 8'hC3; data[1] = 8'h0F; data[2] = 8'h81;
    b0 = busy_cnt;
    send_bytes(3);
    wait_done(400);
    chk("post_abort_busy_cycles", busy_cnt - b0, 160 + 4 * PAR_BITS);

    // Six bytes offered back to back: two frames.
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
    data[3] = 8'h44; data[4] = 8'h55; data[5] = 8'h66;
    bit_period = 14'd2;
    d0 = done_cnt;
    send_bytes(6);
    chk("b2b_first_done_before_byte4", done_cnt - d0, 1);
    wait_done(400);
    chk("b2b_done_pulses", done_cnt - d0, 2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
